// File: rtl/avst_pt_monitor.sv
// N-channel Avalon-ST passthrough: 2-entry skid buffer plus frame-protocol checker and statistics per channel.
// Optional runt/giant length checking is compiled in when PTMON_LEN_CHECK_EN is defined.
module avst_pt_monitor #(
  parameter int NCH     = 2,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2,
  parameter int ERR_W   = 6,
  parameter int CNT_W   = 32,
  parameter int MAX_LEN = 1518
) (
  input  logic                 sys_clk,
  input  logic                 core_reset_n,
  input  logic [NCH*DATA_W-1:0]  in_data,
  input  logic [NCH-1:0]         in_sop,
  input  logic [NCH-1:0]         in_eop,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*EMPTY_W-1:0] in_empty,
  input  logic [NCH*ERR_W-1:0]   in_error,
  output logic [NCH-1:0]         in_ready,
  output logic [NCH*DATA_W-1:0]  out_data,
  output logic [NCH-1:0]         out_sop,
  output logic [NCH-1:0]         out_eop,
  output logic [NCH*EMPTY_W-1:0] out_empty,
  output logic [NCH*ERR_W-1:0]   out_error,
  output logic [NCH-1:0]         out_valid,
  input  logic [NCH-1:0]         out_ready,
  input  logic                   clr,
  output logic [NCH*8-1:0]       err_sticky,
  output logic [NCH*CNT_W-1:0]   frame_cnt,
  output logic [NCH*CNT_W-1:0]   err_frame_cnt
);

  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int BW         = DATA_W + 2 + EMPTY_W + ERR_W;

  typedef enum logic {IDLE, FRAME} state_t;

`ifndef PTMON_LEN_CHECK_EN
  // MAX_LEN only has an effect when the length check is compiled in.
  if (MAX_LEN < 0) begin : g_max_len_unused
  end
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [BW-1:0]      mem [2];
    logic [BW-1:0]      in_beat;
    logic [BW-1:0]      head;
    logic               rd_ptr, wr_ptr, ready_q, push, pop;
    logic [1:0]         count, count_nxt;
    logic               sop, eop, err0;
    logic [EMPTY_W-1:0] empty;

    state_t             state, state_nxt;
    logic               frame_err, frame_err_nxt, beat_err;
    logic               done, done_err;
    logic [3:0]         set_bits;
    logic               len_runt, len_giant;
    logic [5:0]         sticky_q;
    logic [CNT_W-1:0]   fcnt_q, ecnt_q;

    assign sop     = in_sop[c];
    assign eop     = in_eop[c];
    assign empty   = in_empty[c*EMPTY_W +: EMPTY_W];
    assign err0    = in_error[c*ERR_W];
    assign in_beat = {in_data[c*DATA_W +: DATA_W], sop, eop, empty, in_error[c*ERR_W +: ERR_W]};

    assign push      = in_valid[c] & ready_q;
    assign pop       = (count != 2'd0) & out_ready[c];
    assign count_nxt = count + {1'b0, push} - {1'b0, pop};

    // Skid buffer: ready is registered from the next occupancy so it drops only when both entries fill.
    always_ff @(posedge sys_clk or negedge core_reset_n) begin
      if (!core_reset_n) begin
        mem[0]  <= '0;
        mem[1]  <= '0;
        rd_ptr  <= 1'b0;
        wr_ptr  <= 1'b0;
        count   <= 2'd0;
        ready_q <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= in_beat;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count   <= count_nxt;
        ready_q <= (count_nxt != 2'd2);
      end
    end

    assign head                           = mem[rd_ptr];
    assign in_ready[c]                    = ready_q;
    assign out_valid[c]                   = (count != 2'd0);
    assign out_data[c*DATA_W +: DATA_W]   = head[BW-1 -: DATA_W];
    assign out_sop[c]                     = head[ERR_W+EMPTY_W+1];
    assign out_eop[c]                     = head[ERR_W+EMPTY_W];
    assign out_empty[c*EMPTY_W +: EMPTY_W] = head[ERR_W +: EMPTY_W];
    assign out_error[c*ERR_W +: ERR_W]    = head[ERR_W-1:0];

    always_ff @(posedge sys_clk or negedge core_reset_n) begin
      if (!core_reset_n) begin
        state     <= IDLE;
        frame_err <= 1'b0;
      end else begin
        state     <= state_nxt;
        frame_err <= frame_err_nxt;
      end
    end

    // A sop always restarts the frame, whether from IDLE or abandoning an open one.
    always_comb begin
      state_nxt     = state;
      frame_err_nxt = frame_err;
      done          = 1'b0;
      done_err      = 1'b0;
      set_bits      = 4'b0000;
      beat_err      = err0 | ((empty != '0) & ~eop);
      if (push) begin
        set_bits[0] = err0;
        set_bits[1] = (empty != '0) & ~eop;
        if (sop) begin
          set_bits[2] = (state == FRAME);
          if (eop) begin
            done      = 1'b1;
            done_err  = beat_err;
            state_nxt = IDLE;
          end else begin
            state_nxt     = FRAME;
            frame_err_nxt = beat_err;
          end
        end else if (state == IDLE) begin
          set_bits[3] = 1'b1;
        end else if (eop) begin
          done      = 1'b1;
          done_err  = frame_err | beat_err;
          state_nxt = IDLE;
        end else begin
          frame_err_nxt = frame_err | beat_err;
        end
      end
    end

`ifdef PTMON_LEN_CHECK_EN
    logic [15:0] len_q, len_nxt;
    logic [16:0] len_sum, beat_bytes;

    always_comb begin
      beat_bytes = eop ? (17'(BEAT_BYTES) - 17'(empty)) : 17'(BEAT_BYTES);
      len_sum    = (sop ? 17'd0 : {1'b0, len_q}) + beat_bytes;
      len_nxt    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    end

    always_ff @(posedge sys_clk or negedge core_reset_n) begin
      if (!core_reset_n) len_q <= 16'd0;
      else if (push)     len_q <= len_nxt;
    end

    assign len_runt  = (len_nxt < 16'd64);
    assign len_giant = ({16'd0, len_nxt} > 32'(MAX_LEN));
`else
    assign len_runt  = 1'b0;
    assign len_giant = 1'b0;
`endif

    // Status: clear has priority over any set or increment landing on the same edge.
    always_ff @(posedge sys_clk or negedge core_reset_n) begin
      if (!core_reset_n) begin
        sticky_q <= '0;
        fcnt_q   <= '0;
        ecnt_q   <= '0;
      end else if (clr) begin
        sticky_q <= '0;
        fcnt_q   <= '0;
        ecnt_q   <= '0;
      end else begin
        sticky_q <= sticky_q | {done & len_giant, done & len_runt, set_bits};
        if (done) begin
          if (fcnt_q != {CNT_W{1'b1}}) fcnt_q <= fcnt_q + CNT_W'(1);
          if ((done_err | len_runt | len_giant) && (ecnt_q != {CNT_W{1'b1}}))
            ecnt_q <= ecnt_q + CNT_W'(1);
        end
      end
    end

    assign err_sticky[c*8 +: 8]          = {2'b00, sticky_q};
    assign frame_cnt[c*CNT_W +: CNT_W]     = fcnt_q;
    assign err_frame_cnt[c*CNT_W +: CNT_W] = ecnt_q;
  end

endmodule

// File: tb/tb_avst_pt_monitor.sv
// Bench for avst_pt_monitor: beat scoreboard plus a frame-rule status model, random and directed traffic.
// Expectations follow PTMON_LEN_CHECK_EN the same way the design does.
module tb_avst_pt_monitor;
  localparam int NCH = 2, DATA_W = 32, EMPTY_W = 2, ERR_W = 6, CNT_W = 32, MAX_LEN = 1518;
  localparam int BW = DATA_W + 2 + EMPTY_W + ERR_W;

  logic                   sys_clk = 1'b0;
  logic                   core_reset_n = 1'b1;
  logic [NCH*DATA_W-1:0]  in_data = '0;
  logic [NCH-1:0]         in_sop = '0, in_eop = '0, in_valid = '0;
  logic [NCH*EMPTY_W-1:0] in_empty = '0;
  logic [NCH*ERR_W-1:0]   in_error = '0;
  logic [NCH-1:0]         in_ready;
  logic [NCH*DATA_W-1:0]  out_data;
  logic [NCH-1:0]         out_sop, out_eop, out_valid;
  logic [NCH*EMPTY_W-1:0] out_empty;
  logic [NCH*ERR_W-1:0]   out_error;
  logic [NCH-1:0]         out_ready = '1;
  logic                   clr = 1'b0;
  logic [NCH*8-1:0]       err_sticky;
  logic [NCH*CNT_W-1:0]   frame_cnt, err_frame_cnt;

  avst_pt_monitor #(.NCH(NCH), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .ERR_W(ERR_W),
                    .CNT_W(CNT_W), .MAX_LEN(MAX_LEN)) dut (
    .sys_clk(sys_clk), .core_reset_n(core_reset_n),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid),
    .in_empty(in_empty), .in_error(in_error), .in_ready(in_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .out_error(out_error), .out_valid(out_valid), .out_ready(out_ready),
    .clr(clr), .err_sticky(err_sticky), .frame_cnt(frame_cnt), .err_frame_cnt(err_frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int             checks = 0;
  int             errors = 0;
  bit             mon_en = 1'b0;
  logic [NCH-1:0] acc_last = '0;
  logic [BW-1:0]  exp_q [NCH][$];
  bit             m_in_frame [NCH];
  bit             m_bad [NCH];
  int             m_len [NCH];
  logic [7:0]     m_sticky [NCH];
  logic [CNT_W-1:0] m_fcnt [NCH];
  logic [CNT_W-1:0] m_ecnt [NCH];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] packBeat(input logic [DATA_W-1:0] d, input logic s, input logic e,
                                             input logic [EMPTY_W-1:0] em, input logic [ERR_W-1:0] er);
    return {d, s, e, em, er};
  endfunction

  // Frame rules applied to one accepted beat, in terms of whole frames and byte totals.
  task automatic modelBeat(input int ch, input logic s, input logic e, input logic [EMPTY_W-1:0] em,
                           input logic err0);
    bit beat_bad = err0 || (em != 0 && !e);
    int bytes = e ? (DATA_W / 8 - int'(em)) : DATA_W / 8;
    bit runt, giant;
    if (err0) m_sticky[ch][0] = 1'b1;
    if (em != 0 && !e) m_sticky[ch][1] = 1'b1;
    if (!s && !m_in_frame[ch]) begin
      m_sticky[ch][3] = 1'b1;
    end else begin
      if (s) begin
        if (m_in_frame[ch]) m_sticky[ch][2] = 1'b1;
        m_len[ch] = bytes;
        m_bad[ch] = beat_bad;
      end else begin
        m_len[ch] = (m_len[ch] + bytes > 65535) ? 65535 : m_len[ch] + bytes;
        m_bad[ch] = m_bad[ch] | beat_bad;
      end
      m_in_frame[ch] = !e;
      if (e) begin
`ifdef PTMON_LEN_CHECK_EN
        runt  = (m_len[ch] < 64);
        giant = (m_len[ch] > MAX_LEN);
`else
        runt  = 1'b0;
        giant = 1'b0;
`endif
        if (runt) m_sticky[ch][4] = 1'b1;
        if (giant) m_sticky[ch][5] = 1'b1;
        if (m_fcnt[ch] != '1) m_fcnt[ch] = m_fcnt[ch] + 1;
        if ((m_bad[ch] || runt || giant) && m_ecnt[ch] != '1) m_ecnt[ch] = m_ecnt[ch] + 1;
      end
    end
  endtask

  // Sampled mid-cycle: compare DUT against the model, then account for the handshakes of the coming edge.
  always @(negedge sys_clk) begin
    if (mon_en) begin
      for (int ch = 0; ch < NCH; ch++) begin
        checkOutput($sformatf("ch%0d_sticky", ch), err_sticky[ch*8 +: 8], m_sticky[ch]);
        checkOutput($sformatf("ch%0d_frame_cnt", ch), frame_cnt[ch*CNT_W +: CNT_W], m_fcnt[ch]);
        checkOutput($sformatf("ch%0d_err_frame_cnt", ch), err_frame_cnt[ch*CNT_W +: CNT_W], m_ecnt[ch]);
        checkOutput($sformatf("ch%0d_in_ready", ch), in_ready[ch], exp_q[ch].size() != 2);
        checkOutput($sformatf("ch%0d_out_valid", ch), out_valid[ch], exp_q[ch].size() != 0);
        if (out_valid[ch] && out_ready[ch] && exp_q[ch].size() != 0)
          checkOutput($sformatf("ch%0d_out_beat", ch),
                      packBeat(out_data[ch*DATA_W +: DATA_W], out_sop[ch], out_eop[ch],
                               out_empty[ch*EMPTY_W +: EMPTY_W], out_error[ch*ERR_W +: ERR_W]),
                      exp_q[ch].pop_front());
        if (in_valid[ch] && in_ready[ch]) begin
          exp_q[ch].push_back(packBeat(in_data[ch*DATA_W +: DATA_W], in_sop[ch], in_eop[ch],
                                       in_empty[ch*EMPTY_W +: EMPTY_W], in_error[ch*ERR_W +: ERR_W]));
          modelBeat(ch, in_sop[ch], in_eop[ch], in_empty[ch*EMPTY_W +: EMPTY_W], in_error[ch*ERR_W]);
        end
        if (clr) begin
          m_sticky[ch] = '0;
          m_fcnt[ch]   = '0;
          m_ecnt[ch]   = '0;
        end
      end
    end
  end

  task automatic cycle();
    @(negedge sys_clk);
    acc_last = in_valid & in_ready;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input int ch, input logic s, input logic e, input logic [EMPTY_W-1:0] em,
                               input logic err0, output int tries);
    in_data[ch*DATA_W +: DATA_W]    = DATA_W'($urandom);
    in_sop[ch]                      = s;
    in_eop[ch]                      = e;
    in_empty[ch*EMPTY_W +: EMPTY_W] = em;
    in_error[ch*ERR_W +: ERR_W]     = {5'($urandom), err0};
    in_valid[ch]                    = 1'b1;
    tries = 0;
    do begin
      cycle();
      tries++;
    end while (!acc_last[ch] && tries < 50);
    checkOutput($sformatf("ch%0d_beat_accepted", ch), acc_last[ch], 1'b1);
    in_valid[ch] = 1'b0;
  endtask

  task automatic sendFrame(input int ch, input int nbeats, input int err_beat, input int empty_beat);
    int t;
    for (int b = 0; b < nbeats; b++)
      applyStimulus(ch, b == 0, b == nbeats - 1, (b == empty_beat) ? 2'd2 : 2'd0, b == err_beat, t);
  endtask

  task automatic checkStatus(input string tag, input int ch, input logic [7:0] st,
                             input int fc, input int ec);
    checkOutput({tag, "_sticky"}, err_sticky[ch*8 +: 8], st);
    checkOutput({tag, "_frame_cnt"}, frame_cnt[ch*CNT_W +: CNT_W], fc);
    checkOutput({tag, "_err_frame_cnt"}, err_frame_cnt[ch*CNT_W +: CNT_W], ec);
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = '1;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 20) begin
      cycle();
      n++;
    end
    for (int ch = 0; ch < NCH; ch++)
      checkOutput($sformatf("ch%0d_drained", ch), exp_q[ch].size(), 0);
  endtask

  task automatic doReset();
    mon_en   = 1'b0;
    in_valid = '0;
    clr      = 1'b0;
    core_reset_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_ctrl", {out_sop, out_eop, out_empty, out_error}, 0);
    checkOutput("rst_sticky", err_sticky, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_err_frame_cnt", err_frame_cnt, 0);
    for (int ch = 0; ch < NCH; ch++) begin
      exp_q[ch].delete();
      m_in_frame[ch] = 1'b0;
      m_bad[ch]      = 1'b0;
      m_len[ch]      = 0;
      m_sticky[ch]   = '0;
      m_fcnt[ch]     = '0;
      m_ecnt[ch]     = '0;
    end
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    core_reset_n = 1'b1;
    #1;
    checkOutput("in_ready_before_first_edge", in_ready, 0);
    @(posedge sys_clk);
    #1;
    checkOutput("in_ready_after_first_edge", in_ready, 2'b11);
    acc_last = '0;
    mon_en   = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached before the sequence completed");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, total;
    int sent [NCH];
    bit gen_in [NCH];
    logic s, e;
    logic [EMPTY_W-1:0] em;

    doReset();

    // Three 20-beat frames back to back on channel 0 at full rate.
    total = 0;
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 20; b++) begin
        applyStimulus(0, b == 0, b == 19, 2'd0, 1'b0, t);
        total += t;
      end
    checkOutput("ch0_full_rate_cycles", total, 60);
    drain();
    checkStatus("three_frames", 0, 8'h00, 3, 0);

    // Random traffic and random backpressure on both channels.
    acc_last = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      sent[ch]   = 0;
      gen_in[ch] = 1'b0;
    end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (acc_last[ch]) sent[ch]++;
        if (!in_valid[ch] || acc_last[ch]) begin
          if (sent[ch] < 1000 && $urandom_range(0, 9) < 7) begin
            s  = gen_in[ch] ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) >= 3);
            e  = ($urandom_range(0, 9) == 0);
            em = e ? 2'($urandom_range(0, 3)) : (($urandom_range(0, 49) == 0) ? 2'd1 : 2'd0);
            if (s || gen_in[ch]) gen_in[ch] = !e;
            in_data[ch*DATA_W +: DATA_W]    = DATA_W'($urandom);
            in_sop[ch]                      = s;
            in_eop[ch]                      = e;
            in_empty[ch*EMPTY_W +: EMPTY_W] = em;
            in_error[ch*ERR_W +: ERR_W]     = {5'($urandom), ($urandom_range(0, 29) == 0)};
            in_valid[ch]                    = 1'b1;
          end else begin
            in_valid[ch] = 1'b0;
          end
        end
        out_ready[ch] = 1'($urandom_range(0, 1));
      end
      if (sent[0] >= 1000 && sent[1] >= 1000) break;
      cycle();
    end
    in_valid = '0;
    for (int ch = 0; ch < NCH; ch++)
      checkOutput($sformatf("ch%0d_random_beats_sent", ch), sent[ch], 1000);
    drain();

    // Bring both checkers back to IDLE, then clear.
    applyStimulus(0, 1'b1, 1'b1, 2'd0, 1'b0, t);
    applyStimulus(1, 1'b1, 1'b1, 2'd0, 1'b0, t);
    pulseClr();
    checkStatus("after_clr_ch0", 0, 8'h00, 0, 0);
    checkStatus("after_clr_ch1", 1, 8'h00, 0, 0);

    // Abandoned frame then a new sop mid-frame; the restarted frame ends with a MAC error.
    applyStimulus(1, 1'b1, 1'b0, 2'd0, 1'b0, t);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 1'b0, t);
    sendFrame(1, 16, 15, -1);
    checkStatus("sop_in_frame", 1, 8'h05, 1, 1);

    // Non-zero empty on a non-eop beat, then an orphan beat in IDLE.
    pulseClr();
    sendFrame(0, 16, -1, 3);
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, t);
    checkStatus("empty_and_orphan", 0, 8'h0A, 1, 1);

    // Clear coinciding with a frame completion.
    for (int b = 0; b < 15; b++) applyStimulus(0, b == 0, 1'b0, 2'd0, 1'b0, t);
    clr = 1'b1;
    applyStimulus(0, 1'b0, 1'b1, 2'd0, 1'b0, t);
    clr = 1'b0;
    checkStatus("clr_wins", 0, 8'h00, 0, 0);
    sendFrame(0, 16, -1, -1);
    checkStatus("after_clr_frame", 0, 8'h00, 1, 0);

    // Length boundaries: 40 B, 1600 B, 64 B.
    pulseClr();
    sendFrame(0, 10, -1, -1);
`ifdef PTMON_LEN_CHECK_EN
    checkStatus("runt_40B", 0, 8'h10, 1, 1);
`else
    checkStatus("short_40B", 0, 8'h00, 1, 0);
`endif
    sendFrame(0, 400, -1, -1);
`ifdef PTMON_LEN_CHECK_EN
    checkStatus("giant_1600B", 0, 8'h30, 2, 2);
`else
    checkStatus("long_1600B", 0, 8'h00, 2, 0);
`endif
    sendFrame(0, 16, -1, -1);
`ifdef PTMON_LEN_CHECK_EN
    checkStatus("exact_64B", 0, 8'h30, 3, 2);
`else
    checkStatus("exact_64B", 0, 8'h00, 3, 0);
`endif
    drain();

    // Fill channel 0's buffer mid-frame, then reset.
    out_ready[0] = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 2'd0, 1'b0, t);
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 1'b0, t);
    checkOutput("ch0_ready_low_when_full", in_ready[0], 1'b0);
    checkOutput("ch0_valid_when_full", out_valid[0], 1'b1);
    doReset();
    out_ready = '1;
    sendFrame(0, 16, -1, -1);
    drain();
    checkStatus("after_reset_frame", 0, 8'h00, 1, 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avst_pt_monitor.md
# avst_pt_monitor

Parametrised N-channel Avalon-ST passthrough stage with per-channel frame-protocol checking and statistics. It sits between each MAC receive port and the downstream transmit or processing path, at the point where a single rx-to-tx link used to be wired straight through. Each channel forwards beats through a two-entry skid buffer, so upstream ready is registered. A per-channel checker FSM records sticky protocol and MAC error flags and counts good and errored frames.

## Interface
Parameters:
- NCH, 2, number of independent channels
- DATA_W, 32, data bits per channel; must be a multiple of 8
- EMPTY_W, 2, empty field width; equals log2(DATA_W/8)
- ERR_W, 6, MAC receive error field width per channel
- CNT_W, 32, frame counter width
- MAX_LEN, 1518, giant threshold in bytes; used only with PTMON_LEN_CHECK_EN

Ports (channel c occupies slice c of each packed bus):
- sys_clk  in  1  system clock; the only clock domain
- core_reset_n  in  1  asynchronous, active-low reset
- in_data  in  NCH*DATA_W  sink data
- in_sop, in_eop, in_valid  in  NCH  sink framing and valid
- in_empty  in  NCH*EMPTY_W  sink empty bytes
- in_error  in  NCH*ERR_W  MAC error; only bit 0 is checked
- in_ready  out  NCH  sink ready
- out_data, out_sop, out_eop, out_empty, out_error, out_valid  out  widths as for in_*  source side
- out_ready  in  NCH  source ready
- clr  in  1  synchronous clear of the flags and counters
- err_sticky  out  NCH*8  sticky error flags per channel
- frame_cnt  out  NCH*CNT_W  completed frames, saturating
- err_frame_cnt  out  NCH*CNT_W  completed frames with an error, saturating

## Operation
- The channels are fully independent; there is no crossing logic between them.
- **Accepted beat:** in_valid & in_ready for that channel.
- **Skid buffer, 2 entries per channel:**
  - Beats are forwarded unmodified, including error, empty, sop and eop.
  - The buffer never drops a beat and never duplicates a beat.
- **Checker FSM:** two states, IDLE and FRAME. It advances only on accepted beats.
  - IDLE, sop & ~eop → FRAME.
  - IDLE, sop & eop → single-beat frame completes; stays in IDLE.
  - IDLE, beat without sop → set bit3 (orphan beat); stays in IDLE; no frame counted.
  - FRAME, eop without sop → frame completes; → IDLE.
  - FRAME, sop → set bit2 (sop inside frame). The old frame is abandoned and not counted; a new frame starts, obeying the same eop rule as a sop in IDLE.
- **err_sticky bits:**
  - bit0: in_error[0] on any accepted beat.
  - bit1: in_empty ≠ 0 on an accepted non-eop beat.
  - bit2: sop inside frame.
  - bit3: orphan beat.
  - bit4: runt frame.
  - bit5: giant frame.
  - bits 7:6: always 0.
- **Frame errored:** bit0 or bit1 conditions seen on any beat of the frame, or runt, or giant.
- **Counters:**
  - On frame completion, frame_cnt increments by 1.
  - If the frame is errored, err_frame_cnt also increments by 1.
  - Both counters saturate at all-ones.
- **clr:**
  - Zeroes err_sticky, frame_cnt and err_frame_cnt on the next edge.
  - Clear wins over a set or increment in the same cycle.
  - FSM and buffer state are unaffected.

## Timing
- **Reset values:**
  - in_ready = 0; out_valid = 0; all other out_* = 0.
  - err_sticky = 0; both counters = 0; FSM = IDLE; buffer empty.
- in_ready rises on the first sys_clk edge after core_reset_n deasserts.
- in_ready is driven from a register: it is low only when both buffer entries are full.
- **Latency:** a beat accepted at edge N is presented on out_* after edge N, when the buffer is empty and out_ready = 1.
- **Throughput:** 1 beat/cycle sustained while out_ready = 1.
- **Backpressure:**
  - With out_ready = 0, at most 2 beats are absorbed.
  - out_* holds stable while out_valid & ~out_ready.
- **Status latency:** flags and counters reflect an accepted beat one cycle after its accepting edge.
- **Reset mid-frame:** buffered beats are discarded and all state returns to the reset values.

## Configuration
- PTMON_LEN_CHECK_EN defined:
  - A per-channel 16-bit saturating byte counter is compiled in.
  - A beat adds DATA_W/8, or DATA_W/8 − empty on an eop beat.
  - At completion, length < 64 → bit4 (runt); length > MAX_LEN → bit5 (giant).
- PTMON_LEN_CHECK_EN undefined:
  - The length logic is removed; bits 5:4 are tied to 0.
  - Runt/giant never mark a frame errored.

## Test plan
- Channel 0: 3 frames of 20 beats, DATA_W=32, out_ready=1 → output identical beat-for-beat at 1-cycle latency; frame_cnt=3, err_frame_cnt=0, err_sticky=0.
- Random out_ready at 50% on both channels for 1000 beats → no loss or duplication; in_ready low only with 2 entries buffered.
- Frame with in_error[0]=1 on its eop beat, then sop presented while in FRAME → bit0 and bit2 set; err_frame_cnt=1; only the second frame counted in frame_cnt.
- Beat with empty=2 and eop=0, plus a beat without sop while IDLE → bits 1 and 3 set; clr pulsed in the same cycle as a frame completion → all status reads 0.
- With PTMON_LEN_CHECK_EN: 10-beat frame with empty=0 (40 B) → bit4; 400-beat frame (1600 B) → bit5; 16-beat frame with empty=0 (64 B) → no flag.
- Assert core_reset_n low mid-frame with the buffer full → all outputs at reset values; next frame passes cleanly with frame_cnt=1.
